// File: rtl/chunked_serial_adder.sv
// Multi-cycle carry-propagate adder: WIDTH-bit a+b+cin computed CHUNK bits per clock.
// Define ADDER_OVF_EN to add the signed-overflow output o_ovf.
module chunked_serial_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
`ifdef ADDER_OVF_EN
    output logic             o_ovf,
`endif
    output logic [1:0]       o_dbg_state
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // in_ready is high only in IDLE and out_valid only in DONE, so the two never coincide.

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic [IDX_W-1:0] r_idx;
    logic [CHUNK:0]   w_chunk_sum;
    logic [WIDTH-1:0] w_chunk_ext;
    logic [WIDTH-1:0] w_sum_next;
    logic             w_last;
    logic             w_accept;

    assign w_chunk_sum = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]}
                       + {{CHUNK{1'b0}}, r_carry};
    assign w_chunk_ext = WIDTH'(w_chunk_sum[CHUNK-1:0]);
    // Chunks enter at the MSB end so the first (lowest) chunk ends up at bit 0.
    assign w_sum_next  = (r_sum >> CHUNK) | (w_chunk_ext << (WIDTH - CHUNK));
    assign w_last      = (r_idx == IDX_W'(N - 1));

    assign o_in_ready  = (r_state == S_IDLE);
    assign o_out_valid = (r_state == S_DONE);
    assign o_sum       = r_sum;
    assign o_cout      = r_cout;
    assign o_dbg_state = r_state;

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_in_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (i_out_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_idx   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_a     <= i_a;
                r_b     <= i_b;
                r_carry <= i_cin;
                r_idx   <= '0;
            end else if (r_state == S_RUN) begin
                r_a     <= r_a >> CHUNK;
                r_b     <= r_b >> CHUNK;
                r_sum   <= w_sum_next;
                r_carry <= w_chunk_sum[CHUNK];
                if (w_last) begin
                    r_cout <= w_chunk_sum[CHUNK];
                end else begin
                    r_idx  <= r_idx + IDX_W'(1);
                end
            end
        end
    end

`ifdef ADDER_OVF_EN
    logic r_ovf;
    logic w_carry_into_msb;

    // Carry into the top bit is recovered from the top bit's own sum: c = a ^ b ^ s.
    assign w_carry_into_msb = r_a[CHUNK-1] ^ r_b[CHUNK-1] ^ w_chunk_sum[CHUNK-1];
    assign o_ovf            = r_ovf;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ovf <= 1'b0;
        end else if ((r_state == S_RUN) && w_last) begin
            r_ovf <= w_carry_into_msb ^ w_chunk_sum[CHUNK];
        end
    end
`endif

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Bench for chunked_serial_adder: three instances (16/4, 8/8, 16/1) with a shared
// result scoreboard; ovf checks are compiled in when ADDER_OVF_EN is defined.
module tb_chunked_serial_adder;

    logic        clk;
    logic        rst_n;
    logic        iv   [3];
    logic        ordy [3];
    logic [15:0] ia   [3];
    logic [15:0] ib   [3];
    logic        ic   [3];

    wire         ir0, ir1, ir2;
    wire         ov0, ov1, ov2;
    wire         co0, co1, co2;
    wire  [15:0] sm0, sm2;
    wire  [7:0]  sm1;
    wire  [1:0]  st0, st1, st2;
`ifdef ADDER_OVF_EN
    wire         of0, of1, of2;
`endif

    int          n_tests;
    int          n_fail;
    int          cyc;
    logic [17:0] exp_q[$];
    logic [17:0] sb_e;

    chunked_serial_adder #(.WIDTH(16), .CHUNK(4)) u_d0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(iv[0]), .o_in_ready(ir0),
        .i_a(ia[0]), .i_b(ib[0]), .i_cin(ic[0]), .o_out_valid(ov0),
        .i_out_ready(ordy[0]), .o_sum(sm0), .o_cout(co0),
`ifdef ADDER_OVF_EN
        .o_ovf(of0),
`endif
        .o_dbg_state(st0)
    );

    chunked_serial_adder #(.WIDTH(8), .CHUNK(8)) u_d1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(iv[1]), .o_in_ready(ir1),
        .i_a(ia[1][7:0]), .i_b(ib[1][7:0]), .i_cin(ic[1]), .o_out_valid(ov1),
        .i_out_ready(ordy[1]), .o_sum(sm1), .o_cout(co1),
`ifdef ADDER_OVF_EN
        .o_ovf(of1),
`endif
        .o_dbg_state(st1)
    );

    chunked_serial_adder #(.WIDTH(16), .CHUNK(1)) u_d2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(iv[2]), .o_in_ready(ir2),
        .i_a(ia[2]), .i_b(ib[2]), .i_cin(ic[2]), .o_out_valid(ov2),
        .i_out_ready(ordy[2]), .o_sum(sm2), .o_cout(co2),
`ifdef ADDER_OVF_EN
        .o_ovf(of2),
`endif
        .o_dbg_state(st2)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic rd_ready(input int s);
        return (s == 0) ? ir0 : (s == 1) ? ir1 : ir2;
    endfunction

    function automatic logic rd_valid(input int s);
        return (s == 0) ? ov0 : (s == 1) ? ov1 : ov2;
    endfunction

    function automatic logic rd_cout(input int s);
        return (s == 0) ? co0 : (s == 1) ? co1 : co2;
    endfunction

    function automatic logic [15:0] rd_sum(input int s);
        return (s == 0) ? sm0 : (s == 1) ? {8'h00, sm1} : sm2;
    endfunction

`ifdef ADDER_OVF_EN
    function automatic logic rd_ovf(input int s);
        return (s == 0) ? of0 : (s == 1) ? of1 : of2;
    endfunction
`endif

    // Reference model: {ovf, cout, sum}; instance 1 is 8 bits wide.
    function automatic logic [17:0] model(input int s, input logic [15:0] a, input logic [15:0] b,
                                          input logic cin);
        logic [16:0] t;
        logic [15:0] sm;
        logic        c;
        logic        o;
        if (s == 1) begin
            t  = 17'(a[7:0]) + 17'(b[7:0]) + 17'(cin);
            sm = {8'h00, t[7:0]};
            c  = t[8];
            o  = (a[7] == b[7]) && (t[7] != a[7]);
        end else begin
            t  = 17'(a) + 17'(b) + 17'(cin);
            sm = t[15:0];
            c  = t[16];
            o  = (a[15] == b[15]) && (t[15] != a[15]);
        end
        return {o, c, sm};
    endfunction

    // Scoreboard: pops one expected entry per result handshake.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int s = 0; s < 3; s++) begin
                if (rd_valid(s) === 1'b1 && ordy[s] === 1'b1) begin
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_unexpected dut%0d got sum=%h cout=%b, no result expected",
                                 s, rd_sum(s), rd_cout(s));
                    end else begin
                        sb_e = exp_q.pop_front();
                        if ({rd_cout(s), rd_sum(s)} !== sb_e[16:0]) begin
                            n_fail++;
                            $display("FAIL sb_result dut%0d got cout=%b sum=%h exp cout=%b sum=%h",
                                     s, rd_cout(s), rd_sum(s), sb_e[16], sb_e[15:0]);
                        end
`ifdef ADDER_OVF_EN
                        n_tests++;
                        if (rd_ovf(s) !== sb_e[17]) begin
                            n_fail++;
                            $display("FAIL sb_ovf dut%0d got %b exp %b", s, rd_ovf(s), sb_e[17]);
                        end
`endif
                    end
                end
            end
        end
    end

    // Driver tasks
    task automatic drive_op(input int s, input logic [15:0] a, input logic [15:0] b,
                            input logic cin, input bit push);
        int t;
        t = 0;
        while (rd_ready(s) !== 1'b1 && t < 40) begin
            @(posedge clk); #1;
            t++;
        end
        if (rd_ready(s) !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL drive_timeout dut%0d in_ready=%b exp 1", s, rd_ready(s));
            return;
        end
        ia[s] = a;
        ib[s] = b;
        ic[s] = cin;
        iv[s] = 1'b1;
        @(posedge clk); #1;
        iv[s] = 1'b0;
        if (push) exp_q.push_back(model(s, a, b, cin));
    endtask

    task automatic wait_valid(input int s, output int lat);
        lat = 0;
        while (rd_valid(s) !== 1'b1 && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic take_result(input int s);
        ordy[s] = 1'b1;
        @(posedge clk); #1;
        ordy[s] = 1'b0;
    endtask

    // Tests
    task automatic test_reset();
        rst_n = 1'b0;
        for (int s = 0; s < 3; s++) begin
            iv[s] = 1'b0; ordy[s] = 1'b0; ia[s] = '0; ib[s] = '0; ic[s] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int s = 0; s < 3; s++) begin
            n_tests++;
            if (rd_ready(s) !== 1'b1) begin
                n_fail++; $display("FAIL reset_in_ready dut%0d got %b exp 1", s, rd_ready(s));
            end
            n_tests++;
            if (rd_valid(s) !== 1'b0) begin
                n_fail++; $display("FAIL reset_out_valid dut%0d got %b exp 0", s, rd_valid(s));
            end
            n_tests++;
            if (rd_sum(s) !== 16'h0000) begin
                n_fail++; $display("FAIL reset_sum dut%0d got %h exp 0000", s, rd_sum(s));
            end
            n_tests++;
            if (rd_cout(s) !== 1'b0) begin
                n_fail++; $display("FAIL reset_cout dut%0d got %b exp 0", s, rd_cout(s));
            end
        end
    endtask

    task automatic test_basic();
        int lat;
        drive_op(0, 16'h1234, 16'h4321, 1'b0, 1'b1);
        n_tests++;
        if (ir0 !== 1'b0) begin
            n_fail++; $display("FAIL basic_busy in_ready got %b exp 0", ir0);
        end
        wait_valid(0, lat);
        n_tests++;
        if (lat !== 4) begin
            n_fail++; $display("FAIL basic_latency got %0d exp 4", lat);
        end
        take_result(0);
        n_tests++;
        if (ov0 !== 1'b0 || ir0 !== 1'b1) begin
            n_fail++; $display("FAIL basic_release out_valid=%b in_ready=%b exp 0/1", ov0, ir0);
        end
    endtask

    task automatic test_carry_chain();
        int lat;
        drive_op(0, 16'hFFFF, 16'h0000, 1'b1, 1'b1);
        wait_valid(0, lat);
        n_tests++;
        if (lat !== 4) begin
            n_fail++; $display("FAIL carry_latency got %0d exp 4", lat);
        end
        take_result(0);
    endtask

`ifdef ADDER_OVF_EN
    task automatic test_ovf();
        int lat;
        drive_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b1);
        wait_valid(0, lat);
        n_tests++;
        if (of0 !== 1'b1) begin
            n_fail++; $display("FAIL ovf_pos got %b exp 1", of0);
        end
        take_result(0);
        drive_op(0, 16'h8000, 16'h8000, 1'b0, 1'b1);
        wait_valid(0, lat);
        n_tests++;
        if (of0 !== 1'b1) begin
            n_fail++; $display("FAIL ovf_neg got %b exp 1", of0);
        end
        take_result(0);
    endtask
`endif

    task automatic test_backpressure();
        int          lat;
        logic [17:0] e1;
        e1 = model(0, 16'hA5A5, 16'h0F0F, 1'b1);
        drive_op(0, 16'hA5A5, 16'h0F0F, 1'b1, 1'b1);
        wait_valid(0, lat);
        ia[0] = 16'h1111; ib[0] = 16'h2222; ic[0] = 1'b0; iv[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (ov0 !== 1'b1 || ir0 !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold_hs cyc%0d out_valid=%b in_ready=%b exp 1/0", i, ov0, ir0);
            end
            n_tests++;
            if ({co0, sm0} !== e1[16:0]) begin
                n_fail++; $display("FAIL bp_hold_data cyc%0d got %b/%h exp %b/%h", i, co0, sm0, e1[16], e1[15:0]);
            end
            @(posedge clk); #1;
        end
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        ordy[0] = 1'b0;
        n_tests++;
        if (ir0 !== 1'b1 || ov0 !== 1'b0) begin
            n_fail++; $display("FAIL bp_idle in_ready=%b out_valid=%b exp 1/0", ir0, ov0);
        end
        @(posedge clk); #1;
        iv[0] = 1'b0;
        exp_q.push_back(model(0, 16'h1111, 16'h2222, 1'b0));
        n_tests++;
        if (ir0 !== 1'b0) begin
            n_fail++; $display("FAIL bp_second_accept in_ready got %b exp 0", ir0);
        end
        wait_valid(0, lat);
        n_tests++;
        if (lat !== 4) begin
            n_fail++; $display("FAIL bp_second_latency got %0d exp 4", lat);
        end
        take_result(0);
    endtask

    task automatic test_reset_mid();
        int lat;
        drive_op(0, 16'hABCD, 16'h1357, 1'b1, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (ov0 !== 1'b0 || ir0 !== 1'b1 || sm0 !== 16'h0000 || co0 !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async out_valid=%b in_ready=%b sum=%h cout=%b exp 0/1/0000/0", ov0, ir0, sm0, co0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (ov0 !== 1'b0 || ir0 !== 1'b1 || sm0 !== 16'h0000 || co0 !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_release out_valid=%b in_ready=%b sum=%h cout=%b exp 0/1/0000/0", ov0, ir0, sm0, co0);
        end
        drive_op(0, 16'h0001, 16'h0001, 1'b0, 1'b1);
        wait_valid(0, lat);
        n_tests++;
        if (lat !== 4) begin
            n_fail++; $display("FAIL rst_next_latency got %0d exp 4", lat);
        end
        take_result(0);
    endtask

    task automatic test_back_to_back();
        int lat;
        int t;
        int acc;
        int prev;
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
        prev = -1;
        ordy[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a = 16'($urandom_range(0, 65535));
            b = 16'($urandom_range(0, 65535));
            c = 1'($urandom_range(0, 1));
            ia[0] = a; ib[0] = b; ic[0] = c; iv[0] = 1'b1;
            t = 0;
            while (ir0 !== 1'b1 && t < 20) begin
                @(posedge clk); #1;
                t++;
            end
            @(posedge clk);
            acc = cyc;
            #1;
            exp_q.push_back(model(0, a, b, c));
            if (prev >= 0) begin
                n_tests++;
                if (acc - prev !== 6) begin
                    n_fail++; $display("FAIL b2b_interval op%0d got %0d exp 6", i, acc - prev);
                end
            end
            prev = acc;
        end
        iv[0] = 1'b0;
        wait_valid(0, lat);
        @(posedge clk); #1;
        ordy[0] = 1'b0;
    endtask

    task automatic test_degenerate();
        int          lat;
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
        drive_op(1, 16'h00FF, 16'h0001, 1'b1, 1'b1);
        wait_valid(1, lat);
        n_tests++;
        if (lat !== 1) begin
            n_fail++; $display("FAIL degen_latency got %0d exp 1", lat);
        end
        take_result(1);
        for (int i = 0; i < 1000; i++) begin
            a = 16'($urandom_range(0, 65535));
            b = 16'($urandom_range(0, 65535));
            c = 1'($urandom_range(0, 1));
            drive_op(2, a, b, c, 1'b1);
            wait_valid(2, lat);
            n_tests++;
            if (lat !== 16) begin
                n_fail++; $display("FAIL bitserial_latency op%0d got %0d exp 16", i, lat);
            end
            take_result(2);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_basic();
        test_carry_chain();
`ifdef ADDER_OVF_EN
        test_ovf();
`endif
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_degenerate();
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (exp_q.size() !== 0) begin
            n_fail++; $display("FAIL sb_drain pending=%0d exp 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/chunked_serial_adder.md
# chunked_serial_adder

Multi-cycle, parametrised carry-propagate adder that computes `{cout, sum} = a + b + cin` over WIDTH-bit operands, CHUNK bits per clock. A registered carry links successive chunks. It is the area-lean successor to the single-bit combinational full adder. It sits between a valid/ready operand producer and a valid/ready result consumer, and holds one operation at a time.

## Interface

- `WIDTH`, default 16: operand/result width; must be a positive multiple of CHUNK.
- `CHUNK`, default 4: bits added per cycle; 1 ≤ CHUNK ≤ WIDTH.
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `in_valid`, input, 1: operands and cin valid.
- `in_ready`, output, 1: block can accept an operation.
- `a`, input, WIDTH: operand A, unsigned or two's complement.
- `b`, input, WIDTH: operand B.
- `cin`, input, 1: carry-in.
- `out_valid`, output, 1: result valid.
- `out_ready`, input, 1: consumer accepts result.
- `sum`, output, WIDTH: (a+b+cin) mod 2^WIDTH.
- `cout`, output, 1: carry out of bit WIDTH-1.
- `ovf`, output, 1: signed overflow; present only with ADDER_OVF_EN.

## Operation

- N = WIDTH/CHUNK chunks; an index counter runs 0..N-1.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, register a, b and cin into the operand shift registers, clear the index counter, and go to RUN.
- RUN:
  - Each cycle, add the low CHUNK bits of a and b plus the registered carry.
  - Shift the chunk sum into the MSB end of the sum register.
  - Shift a and b right by CHUNK.
  - Update the carry register and increment the index counter.
  - When index = N-1, capture the final carry as cout and go to DONE.
- DONE:
  - out_valid = 1, and sum/cout/ovf are held stable.
  - On out_valid & out_ready, go to IDLE.
- in_ready is 0 in RUN and DONE. in_valid there is ignored, with no queuing.
- Arithmetic matches a ripple of WIDTH full adders exactly: sum = LSBs of a+b+cin and cout = bit WIDTH of the true sum.
- Reset, including mid-RUN or mid-DONE:
  - The FSM goes to IDLE and the operation in flight is discarded.
  - Outputs take their reset values immediately (asynchronous).
- Reset values:
  - in_ready = 1 (held in IDLE; asserted after reset releases).
  - out_valid = 0.
  - sum = 0, cout = 0, ovf = 0.
  - Internal carry and index = 0.

## Timing

- Acceptance at edge k gives RUN from edge k through edge k+N.
- The last chunk is registered at edge k+N.
- out_valid rises in the cycle after edge k+N, so latency from accept to out_valid = N cycles.
- With out_ready held high, the result handshakes at edge k+N+1, and in_ready = 1 in the following cycle.
- Best-case throughput is one operation per N+2 cycles. Results are never dropped while out_ready = 0.
- A result handshake and a new acceptance never occur on the same edge.
- in_ready and out_valid are registered, with no combinational in→out paths.
- The critical path is a CHUNK-bit add plus the carry mux.

## Configuration

- `ADDER_OVF_EN` defined:
  - The `ovf` port exists.
  - ovf = carry into bit WIDTH-1 XOR cout, captured with the final chunk.
  - It is valid with out_valid and holds in DONE.
- Undefined: the `ovf` port and its logic are absent. All other behaviour is identical.

## Test plan

- **Basic add:** WIDTH=16, CHUNK=4, a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0; out_valid rises 4 cycles after acceptance.
- **Carry chain across all chunks:** a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1. With ADDER_OVF_EN, ovf=0.
- **Signed overflow:** with ADDER_OVF_EN, a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1. Also a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
- **Backpressure:** hold out_ready=0 for 5 cycles in DONE.
  - sum, cout and out_valid stay stable and in_ready stays 0.
  - A second in_valid offered meanwhile is not accepted.
  - After out_ready=1, the second operation is accepted in the next IDLE cycle.
- **Reset mid-operation:** assert rst_n=0 two cycles into RUN.
  - out_valid=0, sum=0, cout=0 and in_ready=1 after release.
  - The next operation 0x0001+0x0001 yields 0x0002 with no stale carry.
- **Degenerate config:** CHUNK=WIDTH=8, a=0xFF, b=0x01, cin=1 -> sum=0x01, cout=1, latency 1 cycle. Then 1,000 random vectors with CHUNK=1, WIDTH=16 match a+b+cin.
